cacheline_adapter: RTL and testbench

- Sits between the L1 cache's memory-side port and the burst memory port of the mp3 top level.
- Converts one 256-bit cache-line read or write into a 4-beat, 64-bit burst transaction on the bmem interface.
- Gives the cache a single request/response handshake per line.

---
 rtl/cacheline_adapter.sv | 114 +++++++++++
 tb/tb_cacheline_adapter.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/cacheline_adapter.sv
// Turns one 256-bit cache-line read/write into a 4-beat 64-bit burst on bmem.
// Outputs come from registers or from state/cnt decode only; the cache sees one request/response per line.
module cacheline_adapter #(
   parameter int ADDR_WIDTH = 32,
   parameter int BEAT_WIDTH = 64,
   parameter int BEATS      = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [ADDR_WIDTH-1:0]         line_address,
   input  logic                          line_read,
   input  logic                          line_write,
   input  logic [BEAT_WIDTH*BEATS-1:0]   line_wdata,
   output logic [BEAT_WIDTH*BEATS-1:0]   line_rdata,
   output logic                          line_resp,
   output logic [ADDR_WIDTH-1:0]         bmem_address,
   output logic                          bmem_read,
   output logic                          bmem_write,
   output logic [BEAT_WIDTH-1:0]         bmem_wdata,
   input  logic [BEAT_WIDTH-1:0]         bmem_rdata,
   input  logic                          bmem_resp
);

   localparam int LINE_WIDTH = BEAT_WIDTH * BEATS;
   localparam int CNT_W      = $clog2(BEATS);
   localparam int OFF_W      = $clog2(LINE_WIDTH / 8);
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

   typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

   state_t                                state_q, state_d;
   logic [CNT_W-1:0]                      cnt_q, cnt_d;
   logic [ADDR_WIDTH-1:0]                 addr_q, addr_d;
   logic [BEATS-1:0][BEAT_WIDTH-1:0]      wbuf_q, wbuf_d;
   logic [BEATS-1:0][BEAT_WIDTH-1:0]      rdata_q, rdata_d;
   logic                                  rd_pend_q, rd_pend_d;

   logic unused_offset;
   assign unused_offset = ^line_address[OFF_W-1:0];

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      addr_d    = addr_q;
      wbuf_d    = wbuf_q;
      rdata_d   = rdata_q;
      rd_pend_d = rd_pend_q;
      case (state_q)
         IDLE: begin
            // A simultaneous read is left for the cache to re-present after this write completes.
            if (line_write) begin
               addr_d  = {line_address[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
               wbuf_d  = line_wdata;
               cnt_d   = '0;
               state_d = WR;
            end else if (line_read) begin
               addr_d    = {line_address[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
               cnt_d     = '0;
               rd_pend_d = 1'b1;
               state_d   = RD;
            end
         end
         RD: begin
            if (bmem_resp) begin
               rd_pend_d      = 1'b0;
               rdata_d[cnt_q] = bmem_rdata;
               if (cnt_q == LAST_BEAT) begin
                  cnt_d   = '0;
                  state_d = DONE;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         WR: begin
            if (bmem_resp) begin
               if (cnt_q == LAST_BEAT) begin
                  cnt_d   = '0;
                  state_d = DONE;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         addr_q    <= '0;
         wbuf_q    <= '0;
         rdata_q   <= '0;
         rd_pend_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         addr_q    <= addr_d;
         wbuf_q    <= wbuf_d;
         rdata_q   <= rdata_d;
         rd_pend_q <= rd_pend_d;
      end
   end

   assign line_rdata   = rdata_q;
   assign line_resp    = (state_q == DONE);
   assign bmem_address = addr_q;
   assign bmem_read    = rd_pend_q;
   assign bmem_write   = (state_q == WR);
   assign bmem_wdata   = (state_q == WR) ? wbuf_q[cnt_q] : '0;

endmodule

// File: tb/tb_cacheline_adapter.sv
// Scoreboard bench for cacheline_adapter: line reads/writes against a scripted bmem responder.
module tb_cacheline_adapter;

   logic          clk = 1'b0;
   logic          rst;
   logic [31:0]   line_address;
   logic          line_read, line_write;
   logic [255:0]  line_wdata, line_rdata;
   logic          line_resp;
   logic [31:0]   bmem_address;
   logic          bmem_read, bmem_write;
   logic [63:0]   bmem_wdata, bmem_rdata;
   logic          bmem_resp;

   cacheline_adapter dut (
      .clk(clk), .rst(rst),
      .line_address(line_address), .line_read(line_read), .line_write(line_write),
      .line_wdata(line_wdata), .line_rdata(line_rdata), .line_resp(line_resp),
      .bmem_address(bmem_address), .bmem_read(bmem_read), .bmem_write(bmem_write),
      .bmem_wdata(bmem_wdata), .bmem_rdata(bmem_rdata), .bmem_resp(bmem_resp)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [255:0] rdata;
   } exp_t;
   exp_t          sb[$];
   logic [255:0]  last_rd = '0;

   task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Every completion pops one expected line; line_rdata must hold the most recent read.
   always @(negedge clk) begin
      if (rst === 1'b1 && line_resp === 1'b1) begin
         if (sb.size() == 0) begin
            chk("resp_unexpected", 1, 0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("line_rdata", line_rdata, e.rdata);
         end
      end
   end

   task automatic check_zero(input string tag);
      chk({tag, "_rdata"}, line_rdata, 0);
      chk({tag, "_resp"}, line_resp, 0);
      chk({tag, "_addr"}, bmem_address, 0);
      chk({tag, "_rd"}, bmem_read, 0);
      chk({tag, "_wr"}, bmem_write, 0);
      chk({tag, "_wdata"}, bmem_wdata, 0);
   endtask

   task automatic push_read(input logic [255:0] line);
      exp_t e;
      e.rdata = line;
      sb.push_back(e);
      last_rd = line;
   endtask

   task automatic push_write();
      exp_t e;
      e.rdata = last_rd;
      sb.push_back(e);
   endtask

   // Entered in the first RD cycle; returns in the DONE cycle.
   task automatic serve_read(input logic [3:0][63:0] beats, input int gaps[4]);
      for (int b = 0; b < 4; b++) begin
         for (int g = 0; g <= gaps[b]; g++) begin
            chk($sformatf("rd_req_b%0d", b), bmem_read, (b == 0));
            chk($sformatf("rd_noresp_b%0d", b), line_resp, 0);
            bmem_resp  = (g == gaps[b]);
            bmem_rdata = (g == gaps[b]) ? beats[b] : 64'hDEAD_BEEF_DEAD_BEEF;
            tick();
         end
      end
      bmem_resp = 1'b0;
      chk("rd_done_resp", line_resp, 1);
      chk("rd_done_req", bmem_read, 0);
   endtask

   // Entered in the first WR cycle; returns in the DONE cycle.
   task automatic serve_write(input logic [3:0][63:0] beats, input int gaps[4]);
      for (int b = 0; b < 4; b++) begin
         for (int g = 0; g <= gaps[b]; g++) begin
            chk($sformatf("wr_req_b%0d", b), bmem_write, 1);
            chk($sformatf("wr_wdata_b%0d", b), bmem_wdata, beats[b]);
            chk($sformatf("wr_noresp_b%0d", b), line_resp, 0);
            bmem_resp = (g == gaps[b]);
            tick();
         end
      end
      bmem_resp = 1'b0;
      chk("wr_done_resp", line_resp, 1);
      chk("wr_done_req", bmem_write, 0);
   endtask

   initial begin
      logic [3:0][63:0] rb, wb, sb2;
      int nogap[4];
      int gap1[4];
      nogap = '{0, 0, 0, 0};
      gap1  = '{0, 2, 0, 0};

      // Reset held with random inputs, then bmem_resp with no request.
      rst = 1'b0;
      for (int c = 0; c < 3; c++) begin
         line_read    = 1'($urandom);
         line_write   = 1'($urandom);
         line_address = $urandom;
         line_wdata   = {8{$urandom}};
         bmem_resp    = 1'($urandom);
         bmem_rdata   = {$urandom, $urandom};
         tick();
         check_zero($sformatf("rst%0d", c));
      end
      line_read = 1'b0; line_write = 1'b0; bmem_resp = 1'b1;
      rst = 1'b1;
      for (int c = 0; c < 3; c++) begin
         tick();
         chk("idle_rd", bmem_read, 0);
         chk("idle_wr", bmem_write, 0);
         chk("idle_resp", line_resp, 0);
         chk("idle_rdata", line_rdata, 0);
      end
      bmem_resp = 1'b0;

      // Read 0x1234, back-to-back beats.
      rb = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
            64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
      push_read(rb);
      line_address = 32'h0000_1234; line_read = 1'b1;
      tick();
      chk("rd_addr", bmem_address, 32'h0000_1220);
      serve_read(rb, nogap);
      line_read = 1'b0;
      tick();
      chk("rd_after", line_resp, 0);
      chk("rd_hold", line_rdata, rb);

      // Write 0x40 with a two-cycle stall before the second beat.
      wb = {64'hA3A3_A3A3_A3A3_A3A3, 64'hA2A2_A2A2_A2A2_A2A2,
            64'hA1A1_A1A1_A1A1_A1A1, 64'hA0A0_A0A0_A0A0_A0A0};
      push_write();
      line_address = 32'h0000_0040; line_wdata = wb; line_write = 1'b1;
      tick();
      line_wdata = '1; line_address = 32'hFFFF_FFFF;
      chk("wr_addr", bmem_address, 32'h0000_0040);
      serve_write(wb, gap1);
      line_write = 1'b0;
      tick();
      chk("wr_after", line_resp, 0);

      // Simultaneous read and write: write first, then the still-held read.
      sb2 = {64'h0D0D_0D0D_0000_0004, 64'h0C0C_0C0C_0000_0003,
             64'h0B0B_0B0B_0000_0002, 64'h0A0A_0A0A_0000_0001};
      push_write();
      push_read(sb2);
      line_address = 32'h0000_0100; line_wdata = wb; line_read = 1'b1; line_write = 1'b1;
      tick();
      chk("both_rd", bmem_read, 0);
      serve_write(wb, nogap);
      line_write = 1'b0;
      tick();
      chk("both_idle_rd", bmem_read, 0);
      tick();
      chk("both_rd_addr", bmem_address, 32'h0000_0100);
      serve_read(sb2, '{1, 0, 3, 0});
      line_read = 1'b0;
      tick();

      // Reset during a read, then a clean read to 0x80.
      line_address = 32'h0000_0200; line_read = 1'b1;
      tick();
      bmem_resp = 1'b1; bmem_rdata = 64'h5757_5757_5757_5757;
      tick();
      bmem_resp = 1'b0;
      chk("abort_rd_drop", bmem_read, 0);
      rst = 1'b0; line_read = 1'b0;
      sb.delete();
      last_rd = '0;
      tick();
      check_zero("abort");
      rst = 1'b1;
      tick();
      rb = {64'h8888_0000_0000_0004, 64'h8888_0000_0000_0003,
            64'h8888_0000_0000_0002, 64'h8888_0000_0000_0001};
      push_read(rb);
      line_address = 32'h0000_0080; line_read = 1'b1;
      tick();
      chk("fresh_addr", bmem_address, 32'h0000_0080);
      serve_read(rb, nogap);
      line_read = 1'b0;
      tick();
      tick();

      chk("sb_drained", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

endmodule
